serial_sub: RTL and testbench



---
 rtl/serial_sub.sv | 141 ++++++++++++++
 tb/tb_serial_sub.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// serial_sub: digit-serial unsigned subtractor, DIGIT bits per cycle, LSB chunk first.
// Optional macro SERIAL_SUB_SAT_EN adds the sat port and clamps negative results to zero.
module serial_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_SAT_EN
    ,
    output logic             sat
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             brw_r;
    logic [CW-1:0]    cnt_r;
    logic [DIGIT:0]   chunk_s;
    logic [WIDTH-1:0] d_ext_s;
    logic [WIDTH-1:0] res_nxt_s;
    logic             last_s;

    // Operands are shifted right so the active chunk always sits in the low DIGIT bits;
    // results enter at the top so chunk 0 lands at the bottom after N shifts.
    assign chunk_s   = {1'b0, a_r[DIGIT-1:0]} - {1'b0, b_r[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw_r};
    assign d_ext_s   = WIDTH'(chunk_s[DIGIT-1:0]);
    assign res_nxt_s = (res_r >> DIGIT) | (d_ext_s << (WIDTH - DIGIT));
    assign last_s    = (cnt_r == CW'(N - 1));

    // Next-state selection for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with registered handshake outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            in_ready  <= (state_nxt_s == IDLE);
            out_valid <= (state_nxt_s == DONE);
        end
    end

    // Operand capture, per-chunk subtraction and result publication on the final chunk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            res_r  <= '0;
            brw_r  <= 1'b0;
            cnt_r  <= '0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_SAT_EN
            sat    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        res_r <= '0;
                        brw_r <= 1'b0;
                        cnt_r <= '0;
                    end
                end
                RUN: begin
                    a_r   <= a_r >> DIGIT;
                    b_r   <= b_r >> DIGIT;
                    res_r <= res_nxt_s;
                    brw_r <= chunk_s[DIGIT];
                    cnt_r <= cnt_r + CW'(1);
                    if (last_s) begin
                        borrow <= chunk_s[DIGIT];
`ifdef SERIAL_SUB_SAT_EN
                        diff   <= chunk_s[DIGIT] ? '0 : res_nxt_s;
                        sat    <= chunk_s[DIGIT];
`else
                        diff   <= res_nxt_s;
`endif
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Randomized self-checking bench for serial_sub: an arithmetic transaction model checked every cycle,
// directed literal cases, and a DIGIT=4 instance. Honours SERIAL_SUB_SAT_EN when defined.
module tb_serial_sub;

    localparam int N1 = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] diff;
    logic       borrow;

    logic       in_valid4 = 1'b0;
    logic       out_ready4 = 1'b0;
    logic [7:0] a4 = 8'h00;
    logic [7:0] b4 = 8'h00;
    logic       in_ready4;
    logic       out_valid4;
    logic [7:0] diff4;
    logic       borrow4;
`ifdef SERIAL_SUB_SAT_EN
    logic       sat;
    logic       sat4;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int issued = 0;

    // model state
    int         m_left;
    bit         m_done;
    int         m_accepts = 0;
    logic       e_valid, e_ready, e_borrow, e_sat;
    logic [7:0] e_diff, p_diff;
    logic       p_borrow;

    serial_sub #(.WIDTH(8), .DIGIT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUB_SAT_EN
        , .sat(sat)
`endif
    );

    serial_sub #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .diff(diff4), .borrow(borrow4)
`ifdef SERIAL_SUB_SAT_EN
        , .sat(sat4)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_diff(input logic [7:0] x, input logic [7:0] y);
        int t;
        t = (int'(x) - int'(y) + 256) % 256;
`ifdef SERIAL_SUB_SAT_EN
        if (x < y) t = 0;
`endif
        return t[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Transaction-level model: accept in idle, result appears N edges later, held until taken.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_left   <= 0;
            m_done   <= 1'b0;
            e_valid  <= 1'b0;
            e_ready  <= 1'b1;
            e_diff   <= 8'h00;
            e_borrow <= 1'b0;
            e_sat    <= 1'b0;
        end else if (m_done) begin
            if (out_ready) begin
                m_done  <= 1'b0;
                e_valid <= 1'b0;
                e_ready <= 1'b1;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done   <= 1'b1;
                e_valid  <= 1'b1;
                e_diff   <= p_diff;
                e_borrow <= p_borrow;
`ifdef SERIAL_SUB_SAT_EN
                e_sat    <= p_borrow;
`endif
            end
        end else if (in_valid) begin
            m_left    <= N1;
            e_ready   <= 1'b0;
            p_diff    <= exp_diff(a, b);
            p_borrow  <= (a < b);
            m_accepts <= m_accepts + 1;
        end
    end

    // Cycle-by-cycle comparison of the DIGIT=1 instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'(e_ready));
            check("out_valid", 32'(out_valid), 32'(e_valid));
            check("diff", 32'(diff), 32'(e_diff));
            check("borrow", 32'(borrow), 32'(e_borrow));
`ifdef SERIAL_SUB_SAT_EN
            check("sat", 32'(sat), 32'(e_sat));
`endif
        end
    end

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int hold,
                          input bit keep_valid, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_in_ready", 32'(n < 50), 32'd1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        out_ready = 1'b0;
        issued++;
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op4(input logic [7:0] av, input logic [7:0] bv, output int lat);
        a4 = av;
        b4 = bv;
        in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("d4_diff", 32'(diff4), 32'(exp_diff(av, bv)));
        check("d4_borrow", 32'(borrow4), 32'(av < bv));
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        check("d4_in_ready", 32'(in_ready4), 32'd1);
    endtask

    initial begin
        int lat;
        bit saw_valid;
        logic [7:0] ra, rb;

        rst_n = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);

        // a=9, b=5
        run_op(8'd9, 8'd5, 0, 1'b0, lat);
        check("lat_9_5", 32'(lat), 32'(N1));
        check("diff_9_5", 32'(diff), 32'h04);
        check("borrow_9_5", 32'(borrow), 32'd0);
        check("model_pin_9_5", 32'(e_diff), 32'h04);
        check("ready_after_9_5", 32'(in_ready), 32'd1);

        // a=5, b=9
        run_op(8'd5, 8'd9, 1, 1'b0, lat);
`ifdef SERIAL_SUB_SAT_EN
        check("diff_5_9", 32'(diff), 32'h00);
        check("sat_5_9", 32'(sat), 32'd1);
`else
        check("diff_5_9", 32'(diff), 32'hFC);
`endif
        check("borrow_5_9", 32'(borrow), 32'd1);

        // back-to-back with in_valid held through RUN
        run_op(8'hFF, 8'hFF, 0, 1'b1, lat);
        check("diff_ff_ff", 32'(diff), 32'h00);
        check("borrow_ff_ff", 32'(borrow), 32'd0);
        run_op(8'h00, 8'hFF, 0, 1'b1, lat);
        check("lat_00_ff", 32'(lat), 32'(N1));
`ifdef SERIAL_SUB_SAT_EN
        check("diff_00_ff", 32'(diff), 32'h00);
`else
        check("diff_00_ff", 32'(diff), 32'h01);
`endif
        check("borrow_00_ff", 32'(borrow), 32'd1);

        // consumer stalls five cycles in DONE
        run_op(8'h80, 8'h01, 5, 1'b0, lat);
        check("diff_80_01", 32'(diff), 32'h7F);
        check("borrow_80_01", 32'(borrow), 32'd0);

        // reset during RUN at chunk 4
        a = 8'h11;
        b = 8'h22;
        in_valid = 1'b1;
        issued++;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow), 32'd0);
        saw_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("abort_no_result", 32'(saw_valid), 32'd0);
        run_op(8'd3, 8'd1, 0, 1'b0, lat);
        check("diff_3_1", 32'(diff), 32'h02);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: begin ra = 8'($urandom); rb = ra; end
                1: begin ra = 8'h00; rb = 8'($urandom); end
                2: begin ra = 8'($urandom); rb = 8'hFF; end
                default: begin ra = 8'($urandom); rb = 8'($urandom); end
            endcase
            run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat);
            check("rand_lat", 32'(lat), 32'(N1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // DIGIT=4 instance
        check("d4_idle_ready", 32'(in_ready4), 32'd1);
        run_op4(8'h3C, 8'h4D, lat);
        check("d4_lat", 32'(lat), 32'd2);
`ifdef SERIAL_SUB_SAT_EN
        check("d4_diff_3c_4d", 32'(diff4), 32'h00);
`else
        check("d4_diff_3c_4d", 32'(diff4), 32'hEF);
`endif
        check("d4_borrow_3c_4d", 32'(borrow4), 32'd1);
        for (int i = 0; i < 8; i++) begin
            run_op4(8'($urandom), 8'($urandom), lat);
            check("d4_rand_lat", 32'(lat), 32'd2);
        end

        check("accept_count", 32'(m_accepts), 32'(issued));
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
